// File: rtl/sa_pkg.sv
// sa_pkg: shared widths, lane type and FSM states for the tile sequencer
package sa_pkg;
  localparam int DATA_W = 8;
  localparam int ACC_W = 32;
  typedef enum logic [2:0] {S_IDLE, S_FEED, S_FLUSH, S_DRAIN, S_DONE} sa_seq_state_t;
  typedef logic [DATA_W-1:0] sa_lane_t;
endpackage

// File: rtl/sa_skew_line.sv
// sa_skew_line: DEPTH-stage delay line with async clear; DEPTH=0 is a plain wire
module sa_skew_line #(
  parameter int DEPTH = 1,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  if (DEPTH == 0) begin : g_wire
    logic unused_clk;
    assign unused_clk = clk ^ rstn;
    assign q_o = d_i;
  end else begin : g_sr
    logic [W-1:0] sr_q [DEPTH];
    // shift one stage per cycle, stage 0 takes the input
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
      end else begin
        sr_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
      end
    end
    assign q_o = sr_q[DEPTH-1];
  end
endmodule

// File: rtl/sa_tile_sequencer.sv
// sa_tile_sequencer: streams skewed operand vectors into SA_CORE, drains ROWS results, pulses done; SA_SEQ_PERF_EN adds perf counters
module sa_tile_sequencer
  import sa_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int AW = 10,
  parameter int KW = 10
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [KW-1:0]                 cmd_k,
  input  logic [AW-1:0]                 cmd_abase,
  input  logic [AW-1:0]                 cmd_wbase,
  output logic                          abuf_ren,
  output logic [AW-1:0]                 abuf_addr,
  input  logic [ROWS*DATA_W-1:0]        abuf_rdata,
  output logic                          wbuf_ren,
  output logic [AW-1:0]                 wbuf_addr,
  input  logic [ROWS*DATA_W-1:0]        wbuf_rdata,
  output sa_lane_t [ROWS-1:0]           core_ain,
  output sa_lane_t [ROWS-1:0]           core_win,
  output logic                          core_inpvalid,
  output logic                          core_outread,
  input  logic [ROWS-1:0]               core_rvalid,
  input  logic [ROWS-1:0][ACC_W-1:0]    core_rdata,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [ROWS*ACC_W-1:0]         res_data,
  output logic [$clog2(ROWS)-1:0]       res_idx,
  output logic                          done
`ifdef SA_SEQ_PERF_EN
  ,
  output logic [31:0]                   perf_busy_cyc,
  output logic [31:0]                   perf_stall_cyc
`endif
);
  localparam int FW = $clog2(2*ROWS);
  localparam int IW = $clog2(ROWS);
  localparam int PW = IW + 1;
  sa_seq_state_t state_q, state_d;
  logic [KW-1:0] k_q, k_d, n_q, n_d;
  logic [AW-1:0] abase_q, abase_d, wbase_q, wbase_d;
  logic [FW-1:0] f_q, f_d;
  logic [PW-1:0] pc_q, pc_d;
  logic rdv_q;
  logic res_valid_q, res_valid_d;
  logic [ROWS*ACC_W-1:0] res_data_q, res_data_d;
  logic [IW-1:0] res_idx_q, res_idx_d;
  logic pop, acc;

  assign pop = state_q == S_DRAIN && (&core_rvalid) && (!res_valid_q || res_ready) && pc_q != PW'(ROWS);
  assign acc = res_valid_q && res_ready;
  assign n_d = state_q == S_FEED ? n_q + KW'(1) : '0;
  assign f_d = state_q == S_FLUSH ? f_q + FW'(1) : '0;
  assign pc_d = state_q == S_IDLE ? '0 : pc_q + PW'(pop);
  assign res_valid_d = pop || (res_valid_q && !res_ready);
  assign res_data_d = pop ? core_rdata : res_data_q;
  assign res_idx_d = pop ? pc_q[IW-1:0] : res_idx_q;

  // tile phase sequencing and command latch
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    abase_d = abase_q;
    wbase_d = wbase_q;
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        k_d = cmd_k;
        abase_d = cmd_abase;
        wbase_d = cmd_wbase;
        state_d = cmd_k == '0 ? S_DONE : S_FEED;
      end
      S_FEED: if (n_q == k_q - KW'(1)) state_d = S_FLUSH;
      S_FLUSH: if (f_q == FW'(2*ROWS-2)) state_d = S_DRAIN;
      S_DRAIN: if (acc && res_idx_q == IW'(ROWS-1)) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // state, counters and the downstream result register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      k_q <= '0;
      n_q <= '0;
      abase_q <= '0;
      wbase_q <= '0;
      f_q <= '0;
      pc_q <= '0;
      rdv_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q <= '0;
      res_idx_q <= '0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      n_q <= n_d;
      abase_q <= abase_d;
      wbase_q <= wbase_d;
      f_q <= f_d;
      pc_q <= pc_d;
      rdv_q <= abuf_ren;
      res_valid_q <= res_valid_d;
      res_data_q <= res_data_d;
      res_idx_q <= res_idx_d;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    sa_skew_line #(.DEPTH(r), .W(DATA_W)) u_a (
      .clk, .rstn,
      .d_i(rdv_q ? abuf_rdata[r*DATA_W +: DATA_W] : '0),
      .q_o(core_ain[r])
    );
    sa_skew_line #(.DEPTH(r), .W(DATA_W)) u_w (
      .clk, .rstn,
      .d_i(rdv_q ? wbuf_rdata[r*DATA_W +: DATA_W] : '0),
      .q_o(core_win[r])
    );
  end

  assign cmd_ready = state_q == S_IDLE;
  assign abuf_ren = state_q == S_FEED;
  assign wbuf_ren = abuf_ren;
  assign abuf_addr = abuf_ren ? abase_q + AW'(n_q) : '0;
  assign wbuf_addr = wbuf_ren ? wbase_q + AW'(n_q) : '0;
  assign core_inpvalid = rdv_q || state_q == S_FLUSH;
  assign core_outread = pop;
  assign res_valid = res_valid_q;
  assign res_data = res_data_q;
  assign res_idx = res_idx_q;
  assign done = state_q == S_DONE;

`ifdef SA_SEQ_PERF_EN
  // saturating activity counters, cleared only by reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_busy_cyc <= '0;
      perf_stall_cyc <= '0;
    end else begin
      if (state_q != S_IDLE && !(&perf_busy_cyc)) perf_busy_cyc <= perf_busy_cyc + 32'd1;
      if (state_q == S_DRAIN && res_valid_q && !res_ready && !(&perf_stall_cyc)) perf_stall_cyc <= perf_stall_cyc + 32'd1;
    end
  end
`endif
endmodule
